// File: rtl/call_stack.sv
// Purpose: LIFO stack for PSH/POP data and CLL/RTN return-address linkage.
// Latency: push/call visible on top after 1 edge; pop/ret result on stackout after 1 edge.
// Backpressure: none; overflow/underflow/collide ops are dropped and flagged sticky.
module call_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] pc_in,
    input  logic             clr_err,
    output logic [WIDTH-1:0] stackout,
    output logic [WIDTH-1:0] top,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow,
    output logic             collide
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W:0]   r_count;
    logic [WIDTH-1:0] r_stackout;
    logic             r_overflow;
    logic             r_underflow;
    logic             r_collide;

    logic [3:0]       w_ops;
    logic             w_any;
    logic             w_one;
    logic             w_is_wr;
    logic             w_is_rd;
    logic             w_full;
    logic             w_empty;
    logic             w_do_wr;
    logic             w_do_rd;
    logic             w_ovf_evt;
    logic             w_unf_evt;
    logic             w_col_evt;
    logic [PTR_W:0]   w_cnt_m1;
    logic [PTR_W-1:0] w_wr_idx;
    logic [PTR_W-1:0] w_rd_idx;
    logic [WIDTH-1:0] w_wr_dat;

    // Decode the four request lines; a one-hot request is the only legal operation.
    always_comb begin
        w_ops     = {push, pop, call, ret};
        w_any     = |w_ops;
        w_one     = w_any && ((w_ops & (w_ops - 4'd1)) == 4'd0);
        w_is_wr   = w_one && (push || call);
        w_is_rd   = w_one && (pop || ret);
        w_full    = (r_count == DEPTH[PTR_W:0]);
        w_empty   = (r_count == '0);
        w_do_wr   = w_is_wr && !w_full;
        w_do_rd   = w_is_rd && !w_empty;
        w_ovf_evt = w_is_wr && w_full;
        w_unf_evt = w_is_rd && w_empty;
        w_col_evt = w_any && !w_one;
        // Only the low PTR_W bits address storage; the count MSB only flags full.
        w_cnt_m1  = r_count - {{PTR_W{1'b0}}, 1'b1};
        w_wr_idx  = r_count[PTR_W-1:0];
        w_rd_idx  = w_cnt_m1[PTR_W-1:0];
        w_wr_dat  = push ? din : pc_in;
    end

    // Storage write; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[w_wr_idx] <= w_wr_dat;
        end
    end

    // Occupancy counter and popped-value register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_count    <= '0;
            r_stackout <= '0;
        end else if (w_do_wr) begin
            r_count    <= r_count + {{PTR_W{1'b0}}, 1'b1};
        end else if (w_do_rd) begin
            r_count    <= w_cnt_m1;
            r_stackout <= r_mem[w_rd_idx];
        end
    end

    // Sticky error flags; a new error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_collide   <= 1'b0;
        end else begin
            r_overflow  <= (r_overflow  && !clr_err) || w_ovf_evt;
            r_underflow <= (r_underflow && !clr_err) || w_unf_evt;
            r_collide   <= (r_collide   && !clr_err) || w_col_evt;
        end
    end

    // Status outputs and combinational peek of the top entry.
    always_comb begin
        stackout  = r_stackout;
        count     = r_count;
        full      = w_full;
        empty     = w_empty;
        overflow  = r_overflow;
        underflow = r_underflow;
        collide   = r_collide;
        top       = w_empty ? '0 : r_mem[w_rd_idx];
    end

endmodule

// File: doc/call_stack.md
Name: call_stack

Overview:
- Hardware LIFO stack serving the CPU's PSH/POP data operations and CLL/RTN subroutine linkage.
- Sits beside the ALU. It receives push data (Rs1 value) and return addresses from the decoder/PC logic.
- It returns popped values on `stackout`, which the ALU samples in the exec2 phase.
- Single-clock, registered, one operation per cycle, with full/empty status and sticky error reporting.

Parameters:
- WIDTH, 16, data word width (matches CPU register width)
- DEPTH, 16, number of stack entries; must be a power of two, minimum 2
- PTR_W, 4, log2(DEPTH); the occupancy counter is PTR_W+1 bits

Ports:
- clk  in  1  system clock, rising-edge
- rstn  in  1  asynchronous active-low reset
- push  in  1  PSH request: store din on top of stack
- pop  in  1  POP request: remove top entry and present it on stackout
- call  in  1  CLL request: store pc_in (return address) on top of stack
- ret  in  1  RTN request: remove top entry and present it on stackout
- din  in  WIDTH  data for push (Rs1)
- pc_in  in  WIDTH  return address for call (PC+1 from decoder)
- clr_err  in  1  synchronous clear of the sticky error flags
- stackout  out  WIDTH  registered value of the most recently popped entry
- top  out  WIDTH  combinational peek of the current top entry; 0 when empty
- count  out  PTR_W+1  current occupancy, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- overflow  out  1  sticky: push/call attempted while full
- underflow  out  1  sticky: pop/ret attempted while empty
- collide  out  1  sticky: more than one of push/pop/call/ret asserted in one cycle

Behaviour:
- Reset (rstn low, asynchronous):
  - count=0, stackout=0.
  - overflow, underflow and collide all =0.
  - Storage contents are don't-care and need not be reset.
  - Reset asserted mid-sequence discards all entries immediately.
- Operation decode happens each rising clk edge from {push, pop, call, ret}:
  - None asserted: hold all state.
  - Exactly one asserted: perform that operation.
  - Two or more asserted: perform no operation, set collide, leave count and stackout unchanged.
- push/call, not full:
  - mem[count] <= (push ? din : pc_in); count <= count+1.
  - The new entry is visible on `top` the cycle after the edge.
- push/call, full:
  - Write is suppressed, count unchanged, overflow <= 1.
  - The existing top entry is never overwritten.
- pop/ret, not empty:
  - stackout <= mem[count-1]; count <= count-1.
  - Latency: a request sampled at edge N gives valid stackout after edge N, available to the ALU in the following (exec2) cycle.
  - stackout holds its value until the next successful pop/ret or reset.
- pop/ret, empty:
  - stackout unchanged, count unchanged, underflow <= 1.
- pop and ret are functionally identical, as are push and call apart from the data source. Separate ports are kept for decode clarity.
- Back-to-back operations every cycle are supported with no bubbles. A push followed next cycle by a pop returns the just-pushed value.
- Status outputs:
  - full, empty and top are combinational from count and storage.
  - top = mem[count-1] when count>0, else 0.
- Sticky flags: once set, they stay set until clr_err or reset.
  - clr_err in the same cycle as a new error: the new error wins and the flag ends set.
- Storage addressing uses PTR_W bits. The count MSB is used only for full detection, so there is no wrap-around: the stack never overwrites or reads beyond DEPTH.

Test Plan:
- Reset then idle 3 cycles → count=0, empty=1, full=0, stackout=0, top=0, all error flags 0.
- push din=0x1234, push din=0xABCD, pop, pop → top=0xABCD after the second push; stackout=0xABCD then 0x1234; count ends 0 and empty=1.
- call pc_in=0x0042 then ret → count 1 then 0; stackout=0x0042 one cycle after ret.
- Push DEPTH values 0..15, then one more push din=0xFFFF → full=1, count=16, overflow=1, top=15. Then 16 pops return 15 down to 0 in order; a 17th pop sets underflow with stackout still 0.
- push and pop asserted together with count=2 → collide=1, count stays 2, stackout unchanged. Then clr_err → collide=0.
- Push 3 entries, assert rstn low mid-cycle → count=0 and stackout=0 immediately (asynchronously). A following pop sets underflow.
